fml_memtest: RTL and testbench

- FML 4x64 initiator that exercises the SDRAM controller from the bus side.
- On a start request, writes a deterministic pattern over a range of 32-byte bursts, then reads the range back and counts mismatching 64-bit beats.
- Sits on a spare FML arbiter port. It is driven from a CSR block for board bring-up and for IDELAY/timing calibration sweeps.

---
 rtl/fml_memtest.sv | 172 +++++++++++++++++
 tb/tb_fml_memtest.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fml_memtest.sv
// FML 4x64 memory tester: writes a seeded pattern over a burst range, reads it back, counts bad beats.
// One burst in flight; waits indefinitely on fml_ack; done pulses two cycles after the final read beat.
module fml_memtest #(
    parameter int fml_depth = 26,
    parameter int wr_delay  = 1,
    parameter int rd_delay  = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [fml_depth-6:0] base,
    input  logic [19:0]          count,
    input  logic [31:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          errors,
    output logic [fml_depth-4:0] first_err,
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    input  logic                 fml_ack,
    output logic [7:0]           fml_sel,
    output logic [63:0]          fml_do,
    input  logic [63:0]          fml_di
);
    localparam int BW = fml_depth - 5;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA, END} state_t;

    state_t        state;
    logic [BW-1:0] base_r;
    logic [BW-1:0] burst;
    logic [19:0]   count_r;
    logic [19:0]   n;
    logic [31:0]   seed_r;
    logic [4:0]    cnt;
    logic          err_seen;

    logic [19:0]   n_next;
    logic [BW-1:0] burst_next;
    logic          more;
    logic [4:0]    wr_beat;
    logic [4:0]    rd_beat;
    logic          wr_last;
    logic          rd_last;
    logic          rd_valid;
    logic          rd_bad;

    function automatic logic [63:0] pattern(input logic [31:0] s, input logic [19:0] idx,
                                            input logic [1:0] b);
        logic [31:0] k;
        k = s ^ {10'd0, idx, b};
        return {k, ~k};
    endfunction

    // cnt is the offset of the current cycle from the ack cycle during data phases
    assign n_next     = n + 20'd1;
    assign burst_next = burst + BW'(1);
    assign more       = (n_next < count_r);
    assign wr_beat    = cnt + 5'd1 - 5'(wr_delay);
    assign rd_beat    = cnt - 5'(rd_delay);
    assign wr_last    = (cnt == 5'(wr_delay + 3));
    assign rd_last    = (cnt == 5'(rd_delay + 3));
    assign rd_valid   = (state == RD_DATA) && (rd_beat < 5'd4);
    assign rd_bad     = (fml_di != pattern(seed_r, n, rd_beat[1:0]));
    assign fml_sel    = 8'hFF;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            fml_stb <= 1'b0;
            fml_we  <= 1'b0;
            fml_adr <= '0;
            fml_do  <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        errors    <= '0;
                        first_err <= '0;
                        err_seen  <= 1'b0;
                        busy      <= 1'b1;
                        base_r    <= base;
                        burst     <= base;
                        count_r   <= count;
                        seed_r    <= seed;
                        n         <= '0;
                        cnt       <= '0;
                        if (count == 20'd0) begin
                            state <= END;
                        end else begin
                            state   <= WR_REQ;
                            fml_stb <= 1'b1;
                            fml_we  <= 1'b1;
                            fml_adr <= {base, 5'b0};
                        end
                    end
                end
                WR_REQ: begin
                    if (fml_ack) begin
                        fml_stb <= 1'b0;
                        cnt     <= 5'd1;
                        state   <= WR_DATA;
                        fml_do  <= (wr_beat < 5'd4) ? pattern(seed_r, n, wr_beat[1:0]) : '0;
                    end
                end
                WR_DATA: begin
                    cnt    <= cnt + 5'd1;
                    fml_do <= (wr_beat < 5'd4) ? pattern(seed_r, n, wr_beat[1:0]) : '0;
                    if (wr_last) begin
                        cnt     <= '0;
                        fml_stb <= 1'b1;
                        if (more) begin
                            n       <= n_next;
                            burst   <= burst_next;
                            fml_adr <= {burst_next, 5'b0};
                            fml_we  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            n       <= '0;
                            burst   <= base_r;
                            fml_adr <= {base_r, 5'b0};
                            fml_we  <= 1'b0;
                            state   <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (fml_ack) begin
                        fml_stb <= 1'b0;
                        cnt     <= 5'd1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    cnt <= cnt + 5'd1;
                    if (rd_valid && rd_bad) begin
                        if (errors != 32'hFFFF_FFFF) errors <= errors + 32'd1;
                        if (!err_seen) begin
                            err_seen  <= 1'b1;
                            first_err <= {burst, rd_beat[1:0]};
                        end
                    end
                    if (rd_last) begin
                        cnt <= '0;
                        if (more) begin
                            n       <= n_next;
                            burst   <= burst_next;
                            fml_adr <= {burst_next, 5'b0};
                            fml_stb <= 1'b1;
                            fml_we  <= 1'b0;
                            state   <= RD_REQ;
                        end else begin
                            state <= END;
                        end
                    end
                end
                END: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fml_memtest.sv
// Bench for fml_memtest: FML memory model with burst/data scoreboard plus vector table and corner sequences.
module tb_fml_memtest;
    localparam int FD  = 26;
    localparam int BW  = FD - 5;
    localparam int WRD = 1;
    localparam int RDD = 4;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic           start   = 1'b0;
    logic [BW-1:0]  base    = '0;
    logic [19:0]    count   = '0;
    logic [31:0]    seed    = '0;
    logic           busy;
    logic           done;
    logic [31:0]    errors;
    logic [FD-4:0]  first_err;
    logic [FD-1:0]  fml_adr;
    logic           fml_stb;
    logic           fml_we;
    logic           fml_ack = 1'b0;
    logic [7:0]     fml_sel;
    logic [63:0]    fml_do;
    logic [63:0]    fml_di  = '0;

    fml_memtest #(.fml_depth(FD), .wr_delay(WRD), .rd_delay(RDD)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .base(base), .count(count),
        .seed(seed), .busy(busy), .done(done), .errors(errors), .first_err(first_err),
        .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_ack(fml_ack),
        .fml_sel(fml_sel), .fml_do(fml_do), .fml_di(fml_di)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic          we;
        logic [FD-1:0] adr;
        logic [19:0]   n;
        logic [31:0]   seed;
    } burst_t;

    typedef struct {
        logic [BW-1:0] base;
        logic [19:0]   count;
        logic [31:0]   seed;
        int            lat;
        int            ca;
        int            cb;
        logic [31:0]   exp_err;
        logic [FD-4:0] exp_fe;
    } vec_t;

    burst_t      exp_q[$];
    logic [63:0] data_q[$];
    logic [63:0] mem [logic [FD-4:0]];

    int tests = 0, failed = 0;
    int done_cnt = 0, stb_cycles = 0, ack_cnt = 0, unstable = 0, overlap = 0;
    int ack_lat = 2, corrupt_a = -1, corrupt_b = -1;

    function automatic logic [63:0] pattern(input logic [31:0] s, input logic [19:0] nb,
                                            input logic [1:0] b);
        logic [31:0] k;
        k = s ^ {10'd0, nb, b};
        return {k, ~k};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // memory model: ack after ack_lat waiting cycles, captures writes, returns reads
    initial begin : model
        bit            ph_act, ph_we, waiting;
        int            ph_off, wcnt, b, lim;
        logic [FD-1:0] ph_adr, held_adr;
        logic          held_we;
        logic [FD-4:0] w;
        burst_t        e;
        ph_act = 0; ph_we = 0; waiting = 0; ph_off = 0; wcnt = 0;
        ph_adr = '0; held_adr = '0; held_we = 1'b0;
        forever begin
            @(negedge sys_clk);
            fml_ack = 1'b0;
            fml_di  = '0;
            if (done) done_cnt++;
            if (sys_rst) begin
                ph_act = 0;
                waiting = 0;
                continue;
            end
            if (fml_stb) stb_cycles++;
            if (ph_act) begin
                if (fml_stb) overlap++;
                ph_off++;
                lim = ph_we ? WRD : RDD;
                b = ph_off - lim;
                if (b >= 0 && b < 4) begin
                    w = {ph_adr[FD-1:5], 2'(b)};
                    if (ph_we) begin
                        mem[w] = fml_do;
                        check("wr_data_queued", data_q.size() > 0, 1);
                        if (data_q.size() > 0) check("wr_data", fml_do, data_q.pop_front());
                    end else begin
                        fml_di = mem.exists(w) ? mem[w] : '0;
                        if (int'(w) == corrupt_a || int'(w) == corrupt_b) fml_di[0] = ~fml_di[0];
                    end
                end
                if (ph_off == lim + 3) ph_act = 0;
            end else if (waiting || fml_stb) begin
                if (waiting && (!fml_stb || fml_adr != held_adr || fml_we != held_we)) unstable++;
                if (!waiting) begin
                    waiting = 1; held_adr = fml_adr; held_we = fml_we; wcnt = 0;
                end
                if (wcnt >= ack_lat) begin
                    fml_ack = 1'b1;
                    waiting = 0; ph_act = 1; ph_off = 0; ph_we = fml_we; ph_adr = fml_adr;
                    ack_cnt++;
                    check("burst_queued", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("burst_adr", fml_adr, e.adr);
                        check("burst_we", fml_we, e.we);
                        if (fml_we)
                            for (int k = 0; k < 4; k++) data_q.push_back(pattern(e.seed, e.n, 2'(k)));
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push_expected(input logic [BW-1:0] b0, input logic [19:0] c, input logic [31:0] s);
        burst_t e;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < int'(c); i++) begin
                e.we   = (pass == 0);
                e.n    = 20'(i);
                e.seed = s;
                e.adr  = {b0 + BW'(i), 5'b0};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input logic [BW-1:0] b0, input logic [19:0] c, input logic [31:0] s);
        base = b0; count = c; seed = s; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0, k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check({name, "_finished"}, done_cnt != d0, 1);
        cyc(3);
        check({name, "_done_once"}, done_cnt - d0, 1);
        check({name, "_idle"}, busy, 0);
        check({name, "_all_bursts"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[4];
        int   d0, s0, u0, a0, k;

        vecs[0] = '{21'd0,        20'd4, 32'h0000_0000, 2, -1, -1, 32'd0, 23'd0};
        vecs[1] = '{21'h1F_FFFF,  20'd2, 32'h1234_5678, 0, -1, -1, 32'd0, 23'd0};
        vecs[2] = '{21'd0,        20'd4, 32'h0000_0000, 2,  9, -1, 32'd1, 23'd9};
        vecs[3] = '{21'd8,        20'd3, 32'hA5A5_0000, 1, 43, 32, 32'd2, 23'd32};

        sys_rst = 1'b1;
        cyc(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stb", fml_stb, 0);
        check("rst_we", fml_we, 0);
        check("rst_adr", fml_adr, 0);
        check("rst_do", fml_do, 0);
        check("rst_sel", fml_sel, 8'hFF);
        sys_rst = 1'b0;
        cyc(2);

        for (int i = 0; i < 4; i++) begin
            ack_lat   = vecs[i].lat;
            corrupt_a = vecs[i].ca;
            corrupt_b = vecs[i].cb;
            push_expected(vecs[i].base, vecs[i].count, vecs[i].seed);
            pulse_start(vecs[i].base, vecs[i].count, vecs[i].seed);
            wait_done($sformatf("vec%0d", i), 2000);
            check($sformatf("vec%0d_errors", i), errors, vecs[i].exp_err);
            check($sformatf("vec%0d_first_err", i), first_err, vecs[i].exp_fe);
            if (i == 0) check("vec0_burst1_beat2", mem[23'd6], 64'h00000006_FFFFFFF9);
        end
        check("no_overlap", overlap, 0);

        // results survive a reset
        corrupt_a = -1;
        corrupt_b = -1;
        sys_rst = 1'b1;
        cyc(2);
        sys_rst = 1'b0;
        cyc(1);
        check("rst_hold_errors", errors, 32'd2);
        check("rst_hold_first_err", first_err, 23'd32);
        check("rst_hold_busy", busy, 0);

        // zero-length test
        s0 = stb_cycles;
        d0 = done_cnt;
        pulse_start(21'd0, 20'd0, 32'h55);
        check("zero_busy_c1", busy, 1);
        check("zero_done_c1", done, 0);
        cyc(1);
        check("zero_done_c2", done, 1);
        check("zero_busy_c2", busy, 0);
        cyc(3);
        check("zero_no_stb", stb_cycles - s0, 0);
        check("zero_done_once", done_cnt - d0, 1);
        check("zero_errors", errors, 0);
        check("zero_first_err", first_err, 0);

        // long ack stall with ignored start pulses
        ack_lat = 50;
        u0 = unstable;
        push_expected(21'd3, 20'd2, 32'h1);
        pulse_start(21'd3, 20'd2, 32'h1);
        cyc(10);
        check("stall_stb", fml_stb, 1);
        check("stall_adr", fml_adr, 26'h60);
        pulse_start(21'd100, 20'd7, 32'hFFFF);
        cyc(20);
        pulse_start(21'd0, 20'd0, 32'h0);
        wait_done("stall", 3000);
        check("stall_stable", unstable - u0, 0);
        check("stall_errors", errors, 0);

        // reset during the data phase of burst 1
        ack_lat = 2;
        a0 = ack_cnt;
        d0 = done_cnt;
        push_expected(21'd0, 20'd4, 32'hCAFE);
        pulse_start(21'd0, 20'd4, 32'hCAFE);
        k = 0;
        while (ack_cnt < a0 + 2 && k < 200) begin
            @(posedge sys_clk);
            k++;
        end
        check("midrst_reached_burst1", ack_cnt >= a0 + 2, 1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_busy", busy, 0);
        check("midrst_stb", fml_stb, 0);
        cyc(1);
        sys_rst = 1'b0;
        cyc(5);
        check("midrst_no_done", done_cnt - d0, 0);
        exp_q.delete();
        data_q.delete();

        push_expected(21'd5, 20'd3, 32'h0BAD_F00D);
        pulse_start(21'd5, 20'd3, 32'h0BAD_F00D);
        wait_done("after_rst", 2000);
        check("after_rst_errors", errors, 0);
        check("final_no_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
